// File: rtl/core_pkg.sv
// Shared core types: register file widths and the write-back entry carried
// from execute/memory to the register file write port.
package core_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned INDEX_W = 5;

   typedef struct packed {
      logic [INDEX_W-1:0] index;
      logic [DATA_W-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Pending-write FIFO: slot 0 is the oldest entry; two ordered push ports,
// one pop, and a valid-masked parallel view of every slot for forwarding.
module writeback_fifo
   import core_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push0_valid,
   input  wb_entry_t         push0_entry,
   input  logic              push1_valid,
   input  wb_entry_t         push1_entry,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output wb_entry_t         head,
   output wb_entry_t         entries [DEPTH],
   output logic [DEPTH-1:0]  entry_valid
);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] base;
   logic [CNT_W-1:0] slot1;

   // Pop shifts toward slot 0 first; pushes then land just past the survivors.
   always_comb begin
      mem_d = mem_q;
      base  = count_q;
      if (pop && count_q != '0) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            mem_d[i] = mem_q[i + 1];
         end
         base = count_q - CNT_W'(1);
      end
      slot1 = base + CNT_W'(push0_valid);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push0_valid && CNT_W'(i) == base) begin
            mem_d[i] = push0_entry;
         end
         if (push1_valid && CNT_W'(i) == slot1) begin
            mem_d[i] = push1_entry;
         end
      end
      count_d = slot1 + CNT_W'(push1_valid);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entry_valid[i] = CNT_W'(i) < count_q;
         entries[i]     = entry_valid[i] ? mem_q[i] : '0;
      end
   end

   assign count = count_q;
   assign head  = mem_q[0];

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: serialises ALU and load results in program order onto the
// single register file write port and exposes in-flight writes for bypassing.
module writeback_unit #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned INDEX_W = 5
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mem_valid,
   input  logic [INDEX_W-1:0]           mem_index,
   input  logic [DATA_W-1:0]            mem_data,
   input  logic                         alu_valid,
   input  logic [INDEX_W-1:0]           alu_index,
   input  logic [DATA_W-1:0]            alu_data,
   output logic                         stall,
   output logic [INDEX_W-1:0]           write_index,
   output logic [DATA_W-1:0]            write_data,
   output logic                         WRITE_ENABLE,
   input  logic [INDEX_W-1:0]           read_index_1,
   input  logic [INDEX_W-1:0]           read_index_2,
   output logic                         fwd_hit_1,
   output logic                         fwd_hit_2,
   output logic [DATA_W-1:0]            fwd_data_1,
   output logic [DATA_W-1:0]            fwd_data_2,
   output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

   import core_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] count;
   wb_entry_t        head;
   wb_entry_t        fifo_entries [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
   wb_entry_t        mem_e;
   wb_entry_t        alu_e;
   wb_entry_t        cand;
   wb_entry_t        push0_entry;
   wb_entry_t        push1_entry;
   logic             cand_valid;
   logic             take_mem;
   logic             take_alu;
   logic             pop;
   logic             push0_valid;
   logic             push1_valid;

   // Depends on registered occupancy only, never on the valid inputs.
   assign stall         = (count == CNT_W'(DEPTH));
   assign pending_count = count;

   always_comb begin
      mem_e       = wb_entry_t'{index: mem_index, data: mem_data};
      alu_e       = wb_entry_t'{index: alu_index, data: alu_data};
      take_mem    = mem_valid && !stall;
      take_alu    = alu_valid && !stall;
      cand        = head;
      cand_valid  = 1'b1;
      pop         = 1'b0;
      push0_valid = 1'b0;
      push0_entry = mem_e;
      push1_valid = 1'b0;
      push1_entry = alu_e;
      if (count != '0) begin
         pop = 1'b1;
         if (take_mem) begin
            push0_valid = 1'b1;
            push1_valid = take_alu;
         end else begin
            push0_valid = take_alu;
            push0_entry = alu_e;
         end
      end else if (take_mem) begin
         cand        = mem_e;
         push0_valid = take_alu;
         push0_entry = alu_e;
      end else if (take_alu) begin
         cand = alu_e;
      end else begin
         cand_valid = 1'b0;
      end
   end

   writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push0_valid (push0_valid),
      .push0_entry (push0_entry),
      .push1_valid (push1_valid),
      .push1_entry (push1_entry),
      .pop         (pop),
      .count       (count),
      .head        (head),
      .entries     (fifo_entries),
      .entry_valid (fifo_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         WRITE_ENABLE <= 1'b0;
         write_index  <= '0;
         write_data   <= '0;
      end else begin
         WRITE_ENABLE <= cand_valid;
         if (cand_valid) begin
            write_index <= cand.index;
            write_data  <= cand.data;
         end
      end
   end

   // Oldest-to-youngest scan with later matches overriding, so the youngest wins.
   always_comb begin
      fwd_hit_1  = 1'b0;
      fwd_data_1 = '0;
      fwd_hit_2  = 1'b0;
      fwd_data_2 = '0;
      if (WRITE_ENABLE && write_index == read_index_1) begin
         fwd_hit_1  = 1'b1;
         fwd_data_1 = write_data;
      end
      if (WRITE_ENABLE && write_index == read_index_2) begin
         fwd_hit_2  = 1'b1;
         fwd_data_2 = write_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i] && fifo_entries[i].index == read_index_1) begin
            fwd_hit_1  = 1'b1;
            fwd_data_1 = fifo_entries[i].data;
         end
         if (fifo_valid[i] && fifo_entries[i].index == read_index_2) begin
            fwd_hit_2  = 1'b1;
            fwd_data_2 = fifo_entries[i].data;
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random bench for writeback_unit with an in-order scoreboard of
// expected register file writes.
module tb_writeback_unit;

   import core_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_valid, alu_valid;
   logic [4:0]  mem_index, alu_index;
   logic [15:0] mem_data, alu_data;
   logic        stall;
   logic [4:0]  write_index;
   logic [15:0] write_data;
   logic        WRITE_ENABLE;
   logic [4:0]  read_index_1, read_index_2;
   logic        fwd_hit_1, fwd_hit_2;
   logic [15:0] fwd_data_1, fwd_data_2;
   logic [1:0]  pending_count;

   always #5 clk = ~clk;

   writeback_unit #(.DEPTH(DEPTH), .DATA_W(16), .INDEX_W(5)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem_valid     (mem_valid),
      .mem_index     (mem_index),
      .mem_data      (mem_data),
      .alu_valid     (alu_valid),
      .alu_index     (alu_index),
      .alu_data      (alu_data),
      .stall         (stall),
      .write_index   (write_index),
      .write_data    (write_data),
      .WRITE_ENABLE  (WRITE_ENABLE),
      .read_index_1  (read_index_1),
      .read_index_2  (read_index_2),
      .fwd_hit_1     (fwd_hit_1),
      .fwd_hit_2     (fwd_hit_2),
      .fwd_data_1    (fwd_data_1),
      .fwd_data_2    (fwd_data_2),
      .pending_count (pending_count)
   );

   int          checks   = 0;
   int          failures = 0;
   wb_entry_t   exp_q [$];
   logic        last_we;
   logic [4:0]  last_idx;
   logic [15:0] last_data;
   logic [15:0] rf [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fwd_model(input logic [4:0] idx, output logic hit, output logic [15:0] d);
      hit = 1'b0;
      d   = 16'h0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].index == idx) begin
            hit = 1'b1;
            d   = exp_q[i].data;
            break;
         end
      end
      if (!hit && last_we && last_idx == idx) begin
         hit = 1'b1;
         d   = last_data;
      end
   endtask

   task automatic step(input logic mv, input logic [4:0] mi, input logic [15:0] md,
                       input logic av, input logic [4:0] ai, input logic [15:0] ad);
      logic        st;
      logic        h;
      logic [15:0] d;
      wb_entry_t   e;
      mem_valid = mv; mem_index = mi; mem_data = md;
      alu_valid = av; alu_index = ai; alu_data = ad;
      st = (exp_q.size() == DEPTH);
      chk("stall_pre", 32'(stall), 32'(st));
      if (!st) begin
         if (mv) exp_q.push_back(wb_entry_t'{index: mi, data: md});
         if (av) exp_q.push_back(wb_entry_t'{index: ai, data: ad});
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("we", 32'(WRITE_ENABLE), 32'(1));
         chk("windex", 32'(write_index), 32'(e.index));
         chk("wdata", 32'(write_data), 32'(e.data));
         last_we = 1'b1; last_idx = e.index; last_data = e.data;
      end else begin
         chk("we_idle", 32'(WRITE_ENABLE), 32'(0));
         chk("windex_hold", 32'(write_index), 32'(last_idx));
         chk("wdata_hold", 32'(write_data), 32'(last_data));
         last_we = 1'b0;
      end
      chk("pending", 32'(pending_count), 32'(exp_q.size()));
      chk("stall_post", 32'(stall), 32'(exp_q.size() == DEPTH));
      fwd_model(read_index_1, h, d);
      chk("fwd_hit_1", 32'(fwd_hit_1), 32'(h));
      chk("fwd_data_1", 32'(fwd_data_1), 32'(d));
      fwd_model(read_index_2, h, d);
      chk("fwd_hit_2", 32'(fwd_hit_2), 32'(h));
      chk("fwd_data_2", 32'(fwd_data_2), 32'(d));
      if (WRITE_ENABLE) rf[write_index] = write_data;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      mem_valid = 1'b0; mem_index = '0; mem_data = '0;
      alu_valid = 1'b0; alu_index = '0; alu_data = '0;
      read_index_1 = 5'd0; read_index_2 = 5'd0;
      last_we = 1'b0; last_idx = '0; last_data = '0;
      foreach (rf[i]) rf[i] = 16'h0;
      #12;
      chk("rst_we", 32'(WRITE_ENABLE), 32'(0));
      chk("rst_windex", 32'(write_index), 32'(0));
      chk("rst_wdata", 32'(write_data), 32'(0));
      chk("rst_pending", 32'(pending_count), 32'(0));
      chk("rst_stall", 32'(stall), 32'(0));
      reset_n = 1'b1;

      // single ALU result, then one idle cycle
      step(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h1234);
      chk("alu_single_data", 32'(write_data), 32'h1234);
      idle();

      // mem/alu collision
      step(1'b1, 5'd5, 16'hAAAA, 1'b1, 5'd6, 16'hBBBB);
      chk("coll_pending1", 32'(pending_count), 32'(1));
      idle();
      chk("coll_second", 32'(write_index), 32'(6));
      idle();

      // fill to DEPTH; third pair is ignored
      step(1'b1, 5'd10, 16'h0A01, 1'b1, 5'd11, 16'h0B01);
      step(1'b1, 5'd12, 16'h0A02, 1'b1, 5'd13, 16'h0B02);
      chk("fill_full", 32'(pending_count), 32'(2));
      chk("fill_stall", 32'(stall), 32'(1));
      step(1'b1, 5'd14, 16'hDEAD, 1'b1, 5'd15, 16'hBEEF);
      chk("fill_unstall", 32'(stall), 32'(0));
      idle();
      idle();
      idle();

      // forwarding: output register and FIFO both hold index 7
      read_index_1 = 5'd7; read_index_2 = 5'd8;
      step(1'b1, 5'd7, 16'h0001, 1'b1, 5'd7, 16'h0002);
      chk("fwd_dir_hit1", 32'(fwd_hit_1), 32'(1));
      chk("fwd_dir_data1", 32'(fwd_data_1), 32'h0002);
      chk("fwd_dir_hit2", 32'(fwd_hit_2), 32'(0));
      chk("fwd_dir_data2", 32'(fwd_data_2), 32'(0));
      idle();
      idle();

      // same index twice; last write wins in the register file
      step(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 16'h1111);
      step(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 16'h2222);
      idle();
      chk("rf9_last", 32'(rf[9]), 32'h2222);

      // index 0 is an ordinary register
      step(1'b1, 5'd0, 16'h5A5A, 1'b0, 5'd0, 16'h0);
      idle();

      // random traffic with random read indices
      for (int n = 0; n < 80; n++) begin
         read_index_1 = 5'($urandom_range(0, 7));
         read_index_2 = 5'($urandom_range(0, 7));
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom));
      end
      for (int n = 0; n < 4; n++) idle();

      // reset mid-stream with a full FIFO
      step(1'b1, 5'd1, 16'h0011, 1'b1, 5'd2, 16'h0022);
      step(1'b1, 5'd3, 16'h0033, 1'b1, 5'd4, 16'h0044);
      mem_valid = 1'b0; alu_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_we", 32'(WRITE_ENABLE), 32'(0));
      chk("mid_rst_windex", 32'(write_index), 32'(0));
      chk("mid_rst_wdata", 32'(write_data), 32'(0));
      chk("mid_rst_pending", 32'(pending_count), 32'(0));
      chk("mid_rst_stall", 32'(stall), 32'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      last_we = 1'b0; last_idx = '0; last_data = '0;
      for (int n = 0; n < 4; n++) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the pipelined core and the sole driver of the register file write port. It accepts results from the execute stage (ALU) and the memory stage (loads), which can complete in the same cycle. It serialises them in program order onto the single 16-bit write port through a small FIFO. It also reports in-flight writes so decode can bypass values not yet committed to the register file.

## Interface
- DEPTH, 2, pending-write FIFO entries (≥2)
- DATA_W, 16, register data width
- INDEX_W, 5, register index width (32 registers)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mem_valid  in  1  load result present
- mem_index  in  INDEX_W  load destination
- mem_data  in  DATA_W  load data
- alu_valid  in  1  ALU result present
- alu_index  in  INDEX_W  ALU destination
- alu_data  in  DATA_W  ALU data
- stall  out  1  FIFO full; upstream must hold, and inputs are ignored
- write_index  out  INDEX_W  register file write index (registered)
- write_data  out  DATA_W  register file write data (registered)
- WRITE_ENABLE  out  1  register file write strobe (registered)
- read_index_1, read_index_2  in  INDEX_W  decode read indices
- fwd_hit_1, fwd_hit_2  out  1  an in-flight write targets that index
- fwd_data_1, fwd_data_2  out  DATA_W  youngest in-flight data for that index, 0 when there is no hit
- pending_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Program order within a cycle: the mem input is older than the alu input.
- Each cycle the candidate order is FIFO head, then mem, then alu. Inputs count only when their valid is high and stall is low.
- The first candidate loads the output register: WRITE_ENABLE=1, with its index and data. If there is no candidate, WRITE_ENABLE=0, and write_index/write_data hold their previous values.
- The remaining accepted inputs are pushed into the FIFO in order: mem first, then alu.
- Occupancy change per cycle is in {-1, 0, +1}. stall = (pending_count == DEPTH). Because at most one push net occurs per cycle, there is no overflow.
- Index 0 is an ordinary register and is written normally.
- Forwarding is combinational. The search runs over the FIFO entries (youngest first), then the output register if WRITE_ENABLE=1. The first match drives fwd_hit and fwd_data. Same-cycle inputs are not forwarded.
- Repeated writes to the same index are all committed in order, so the last one wins in the register file.

## Timing
- Reset (asynchronous): WRITE_ENABLE=0, write_index=0, write_data=0, FIFO emptied, pending_count=0, stall=0. Reset mid-operation discards all pending writes, and none are issued after release.
- Latency with an empty FIFO: an input accepted at edge N appears on the write port after edge N. The register file captures it at edge N+1.
- Queued entry: it drains one per cycle in FIFO order, with no bubbles while the FIFO is non-empty.
- stall is a function of registered state only, with no combinational path from the valid inputs.
- Full FIFO with both inputs valid: inputs are ignored, the head is popped, and pending_count drops by 1. stall deasserts in the next cycle.

## Structure
- The shared package `core_pkg` holds DATA_W=16, INDEX_W=5, and the `wb_entry_t` struct {index, data}. It is shared with the register file and the decode stage.
- One sub-module: `writeback_fifo`. It is a synchronous FIFO of `wb_entry_t` with two ordered push ports, one pop, a count output, and a parallel read of all entries (valid-masked) for the forwarding search.
- The top level holds the output register, the candidate selection, and the forwarding priority logic.

## Test plan
- Reset: assert reset_n=0 mid-stream -> WRITE_ENABLE=0, write_index=0, write_data=0, pending_count=0, stall=0. No write occurs after release.
- Single ALU result: alu (3, 0x1234) at edge N -> after N, WRITE_ENABLE=1, write_index=3, write_data=0x1234 for exactly one cycle; then WRITE_ENABLE=0.
- Collision: mem (5, 0xAAAA) and alu (6, 0xBBBB) in the same cycle -> write 5/0xAAAA, then 6/0xBBBB on consecutive cycles; pending_count goes 1 then 0.
- Fill with DEPTH=2: mem+alu valid on 3 consecutive cycles -> pending_count 1, then 2 with stall=1. Third-cycle data is never written. Four writes drain in order, and stall clears after one cycle.
- Forwarding: index 7 in the output register (0x0001) and in the FIFO (0x0002), read_index_1=7 -> fwd_hit_1=1, fwd_data_1=0x0002. With read_index_2=8 and no match -> fwd_hit_2=0, fwd_data_2=0.
- Same index twice: alu (9, 0x1111) then alu (9, 0x2222) -> both written in order; a register file read of index 9 returns 0x2222.
